// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop rx synchroniser and mid-bit sampling.
// Reports each good byte with a one-cycle rx_valid pulse and a low stop bit with frame_err.
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int BAUDRATE       = 115200,
    parameter int CLK_FREQ_MHZ   = 125,
    parameter int BAUDRATE_COUNT = CLK_FREQ_MHZ * 1_000_000 / BAUDRATE,
    parameter int HALF_COUNT     = BAUDRATE_COUNT / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int CNT_W = $clog2(BAUDRATE_COUNT);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic                  r_rx_d;
    logic [1:0]            r_sync_fill;
    logic                  r_armed;
    logic [CNT_W-1:0]      r_baud_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  w_fall;
    logic                  w_tick;

    assign w_fall  = r_armed & r_rx_d & ~r_rx_s;
    assign w_tick  = (r_baud_cnt == CNT_W'(BAUDRATE_COUNT - 1));
    assign rx_busy = (r_state != S_IDLE);

    // r_armed waits until r_rx_s carries a genuinely sampled high level, so the
    // synchroniser's reset value can never masquerade as a start edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_d      <= 1'b0;
            r_sync_fill <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
            r_rx_d      <= r_rx_s;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            if (r_sync_fill[1] && r_rx_s)
                r_armed <= 1'b1;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_state_nxt = S_START;
            S_START: if (r_baud_cnt == CNT_W'(HALF_COUNT - 1))
                         w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)))
                         w_state_nxt = S_STOP;
            S_STOP:  if (w_tick) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) || (w_state_nxt != r_state) || w_tick)
                r_baud_cnt <= '0;
            else
                r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            data_o    <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if ((r_state == S_DATA) && w_tick) begin
                r_shift   <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
                r_bit_cnt <= (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) ? '0 : r_bit_cnt + 1'b1;
            end
            if ((r_state == S_STOP) && w_tick) begin
                if (r_rx_s) begin
                    data_o   <= r_shift;
                    rx_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
